// File: rtl/mandel_load_dist.sv
// Round-robin job dispatcher and result collector for a bank of Mandelbrot solvers.
// Optional frame cycle statistics are enabled with LOADDIST_STATS_EN.
module mandel_load_dist #(
  parameter int NUM_SOLVERS  = 4,
  parameter int ITER_W       = 10,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          iDraw,
  input  logic                          iCoordVal,
  input  logic [9:0]                    iVGAX,
  input  logic [8:0]                    iVGAY,
  input  logic [35:0]                   iCoordX,
  input  logic [35:0]                   iCoordY,
  output logic                          oLoadDistRdy,
  output logic [NUM_SOLVERS-1:0]        oSolverStart,
  output logic [NUM_SOLVERS-1:0]        oSolverAbort,
  output logic [35:0]                   oSolverCr,
  output logic [35:0]                   oSolverCi,
  input  logic [NUM_SOLVERS-1:0]        iSolverDone,
  input  logic [NUM_SOLVERS*ITER_W-1:0] iSolverIter,
  output logic [NUM_SOLVERS-1:0]        oSolverAck,
  output logic                          oPixVal,
  output logic [9:0]                    oPixX,
  output logic [8:0]                    oPixY,
  output logic [ITER_W-1:0]             oPixIter,
  input  logic                          iPixRdy,
  output logic                          oFrameDone,
  output logic [31:0]                   oFrameCycles
);

  localparam int PW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam logic [18:0] FRAME_LAST = 19'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } slot_t;

  typedef enum logic [1:0] {
    T_RUN,
    T_COMPLETE,
    T_FLUSH
  } top_t;

  slot_t         slot_st [NUM_SOLVERS];
  logic [9:0]    tag_x   [NUM_SOLVERS];
  logic [8:0]    tag_y   [NUM_SOLVERS];
  logic [PW-1:0] dptr;
  logic [PW-1:0] cptr;
  logic [18:0]   pix_cnt;
  top_t          top;
  top_t          top_n;

  logic          tgt_hit;
  logic [PW-1:0] tgt;
  logic          col_hit;
  logic [PW-1:0] col;
  logic          accept;
  logic          collect;
  logic          xfer;
  logic          frame_hit;
  logic          any_idle_n;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) == NUM_SOLVERS - 1) return '0;
    return p + PW'(1);
  endfunction

  // Cyclic first-match search from each pointer.
  always_comb begin
    int di;
    int ci;
    tgt_hit = 1'b0;
    tgt     = '0;
    col_hit = 1'b0;
    col     = '0;
    di      = 0;
    ci      = 0;
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      di = int'(dptr) + i;
      if (di >= NUM_SOLVERS) di = di - NUM_SOLVERS;
      ci = int'(cptr) + i;
      if (ci >= NUM_SOLVERS) ci = ci - NUM_SOLVERS;
      if (!tgt_hit && slot_st[di] == S_IDLE) begin
        tgt_hit = 1'b1;
        tgt     = PW'(di);
      end
      if (!col_hit && slot_st[ci] == S_DONE) begin
        col_hit = 1'b1;
        col     = PW'(ci);
      end
    end
  end

  assign accept    = iCoordVal && oLoadDistRdy && !iDraw;
  assign xfer      = oPixVal && iPixRdy;
  assign collect   = col_hit && (!oPixVal || iPixRdy) && !iDraw;
  assign frame_hit = xfer && (pix_cnt == FRAME_LAST);

  always_comb begin
    top_n = top;
    if (iDraw) begin
      top_n = T_FLUSH;
    end else if (top == T_FLUSH) begin
      top_n = T_RUN;
    end else if (top == T_RUN && frame_hit) begin
      top_n = T_COMPLETE;
    end
  end

  // Ready is registered from the slot states as they will be next cycle.
  always_comb begin
    any_idle_n = 1'b0;
    for (int k = 0; k < NUM_SOLVERS; k++) begin
      if ((slot_st[k] == S_IDLE && !(accept && int'(tgt) == k)) ||
          (collect && int'(col) == k)) begin
        any_idle_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_SOLVERS; k++) begin
        slot_st[k] <= S_IDLE;
        tag_x[k]   <= '0;
        tag_y[k]   <= '0;
      end
      dptr         <= '0;
      cptr         <= '0;
      pix_cnt      <= '0;
      top          <= T_RUN;
      oLoadDistRdy <= 1'b0;
      oSolverStart <= '0;
      oSolverAbort <= '0;
      oSolverAck   <= '0;
      oSolverCr    <= '0;
      oSolverCi    <= '0;
      oPixVal      <= 1'b0;
      oPixX        <= '0;
      oPixY        <= '0;
      oPixIter     <= '0;
      oFrameDone   <= 1'b0;
    end else begin
      top          <= top_n;
      oLoadDistRdy <= (top_n == T_RUN) && any_idle_n;
      oSolverStart <= '0;
      oSolverAbort <= '0;
      oSolverAck   <= '0;
      if (iDraw) begin
        for (int k = 0; k < NUM_SOLVERS; k++) begin
          oSolverAbort[k] <= (slot_st[k] != S_IDLE);
          slot_st[k]      <= S_IDLE;
        end
        dptr       <= '0;
        cptr       <= '0;
        pix_cnt    <= '0;
        oPixVal    <= 1'b0;
        oFrameDone <= 1'b0;
      end else begin
        for (int k = 0; k < NUM_SOLVERS; k++) begin
          if (slot_st[k] == S_RUN && iSolverDone[k]) slot_st[k] <= S_DONE;
        end
        if (accept) begin
          slot_st[tgt]      <= S_RUN;
          tag_x[tgt]        <= iVGAX;
          tag_y[tgt]        <= iVGAY;
          oSolverStart[tgt] <= 1'b1;
          oSolverCr         <= iCoordX;
          oSolverCi         <= iCoordY;
          dptr              <= ptr_inc(tgt);
        end
        if (xfer) begin
          oPixVal <= 1'b0;
          pix_cnt <= pix_cnt + 19'd1;
          if (frame_hit) oFrameDone <= 1'b1;
        end
        // Reload in the same cycle the held result is taken.
        if (collect) begin
          oPixVal         <= 1'b1;
          oPixX           <= tag_x[col];
          oPixY           <= tag_y[col];
          oPixIter        <= iSolverIter[int'(col)*ITER_W +: ITER_W];
          oSolverAck[col] <= 1'b1;
          slot_st[col]    <= S_IDLE;
          cptr            <= ptr_inc(col);
        end
      end
    end
  end

`ifdef LOADDIST_STATS_EN
  logic [31:0] fc;
  logic        fc_run;
  logic        fc_hold;

  always_ff @(posedge clk) begin
    if (reset || iDraw) begin
      fc      <= '0;
      fc_run  <= 1'b0;
      fc_hold <= 1'b0;
    end else if (!fc_run && !fc_hold && accept) begin
      fc_run <= 1'b1;
      fc     <= 32'd1;
    end else if (fc_run) begin
      if (fc != 32'hFFFF_FFFF) fc <= fc + 32'd1;
      if (frame_hit) begin
        fc_run  <= 1'b0;
        fc_hold <= 1'b1;
      end
    end
  end

  assign oFrameCycles = fc;
`else
  assign oFrameCycles = '0;
`endif

endmodule

// File: tb/tb_mandel_load_dist.sv
// Directed bench for mandel_load_dist with a 16-pixel frame.
// Hand-computed expectations for dispatch, collect, stall, flush and frame end.
module tb_mandel_load_dist;

  logic        clk = 1'b0;
  logic        reset;
  logic        draw;
  logic        coord_val;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic [35:0] cx;
  logic [35:0] cy;
  logic        rdy;
  logic [3:0]  start;
  logic [3:0]  abort;
  logic [35:0] cr;
  logic [35:0] ci;
  logic [3:0]  s_done;
  logic [39:0] s_iter;
  logic [3:0]  ack;
  logic        pix_val;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [9:0]  pix_iter;
  logic        pix_rdy;
  logic        frame_done;
  logic [31:0] frame_cyc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mandel_load_dist #(
    .NUM_SOLVERS (4),
    .ITER_W      (10),
    .FRAME_PIXELS(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iDraw       (draw),
    .iCoordVal   (coord_val),
    .iVGAX       (vga_x),
    .iVGAY       (vga_y),
    .iCoordX     (cx),
    .iCoordY     (cy),
    .oLoadDistRdy(rdy),
    .oSolverStart(start),
    .oSolverAbort(abort),
    .oSolverCr   (cr),
    .oSolverCi   (ci),
    .iSolverDone (s_done),
    .iSolverIter (s_iter),
    .oSolverAck  (ack),
    .oPixVal     (pix_val),
    .oPixX       (pix_x),
    .oPixY       (pix_y),
    .oPixIter    (pix_iter),
    .iPixRdy     (pix_rdy),
    .oFrameDone  (frame_done),
    .oFrameCycles(frame_cyc)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    int acc_n;
    int wr_n;
    int ca;
    int cd;
    int acc_at_done;
    int wr_at_done;
    bit acc;
    reset = 1'b1;
    draw = 1'b0;
    coord_val = 1'b0;
    vga_x = '0;
    vga_y = '0;
    cx = '0;
    cy = '0;
    s_done = '0;
    s_iter = '0;
    pix_rdy = 1'b0;
    repeat (3) tick();
    chk("rst_rdy", rdy, 0);
    chk("rst_pixval", pix_val, 0);
    chk("rst_start", start, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_fcyc", frame_cyc, 0);
    reset = 1'b0;
    tick();
    chk("rdy_up", rdy, 1);

    // four back-to-back dispatches
    for (int i = 0; i < 4; i++) begin
      coord_val = 1'b1;
      vga_x = 10'(100 + i);
      vga_y = 9'(50 + i);
      cx = 36'h1_0000_0000 + 36'(i);
      cy = 36'h2_0000_0000 + 36'(i);
      tick();
      chk("start", start, 64'(1 << i));
      chk("cr", cr, 36'h1_0000_0000 + 36'(i));
      chk("ci", ci, 36'h2_0000_0000 + 36'(i));
    end
    chk("rdy_full", rdy, 0);
    coord_val = 1'b0;
    tick();
    chk("start_quiet", start, 0);

    // slot 0 finishes alone, moving the collect pointer to 1
    s_done[0] = 1'b1;
    s_iter[9:0] = 10'd7;
    pix_rdy = 1'b1;
    tick();
    chk("res_lat", pix_val, 0);
    tick();
    chk("res0", {pix_val, ack, pix_x, pix_y, pix_iter},
        {1'b1, 4'b0001, 10'd100, 9'd50, 10'd7});
    chk("rdy_freed", rdy, 1);
    s_done[0] = 1'b0;
    coord_val = 1'b1;
    vga_x = 10'd200;
    vga_y = 9'd60;
    cx = 36'h3_0000_0000;
    tick();
    chk("redispatch", {start, pix_val}, {4'b0001, 1'b0});
    coord_val = 1'b0;

    // slots 2 and 0 together: slot 2 wins from pointer 1
    s_done = 4'b0101;
    s_iter[9:0] = 10'd33;
    s_iter[29:20] = 10'd22;
    tick();
    tick();
    chk("res2", {pix_val, ack, pix_x, pix_y, pix_iter},
        {1'b1, 4'b0100, 10'd102, 9'd52, 10'd22});
    s_done[2] = 1'b0;
    tick();
    chk("res0b", {pix_val, ack, pix_x, pix_y, pix_iter},
        {1'b1, 4'b0001, 10'd200, 9'd60, 10'd33});
    s_done[0] = 1'b0;

    // writer stall holds the output and blocks collection
    pix_rdy = 1'b0;
    s_done[1] = 1'b1;
    s_iter[19:10] = 10'd44;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall", {pix_val, ack, pix_x, pix_iter},
          {1'b1, 4'b0000, 10'd200, 10'd33});
    end
    pix_rdy = 1'b1;
    tick();
    chk("res1", {pix_val, ack, pix_x, pix_y, pix_iter},
        {1'b1, 4'b0010, 10'd101, 9'd51, 10'd44});
    s_done[1] = 1'b0;

    // fill slots 1 and 2, keep a result pending, then flush
    pix_rdy = 1'b0;
    coord_val = 1'b1;
    vga_x = 10'd300;
    tick();
    chk("start_s1", start, 4'b0010);
    vga_x = 10'd301;
    tick();
    chk("start_s2", start, 4'b0100);
    coord_val = 1'b0;
    draw = 1'b1;
    tick();
    chk("flush", {abort, pix_val, rdy}, {4'b1110, 1'b0, 1'b0});
    draw = 1'b0;
    tick();
    chk("post_flush", {abort, rdy}, {4'b0000, 1'b1});

    // full 16-pixel frame with instant solvers
    acc_n = 0;
    wr_n = 0;
    ca = -1;
    cd = -1;
    acc_at_done = 0;
    wr_at_done = 0;
    s_done = '0;
    pix_rdy = 1'b1;
    coord_val = 1'b1;
    vga_x = 10'd0;
    vga_y = 9'd0;
    cx = 36'd0;
    for (int n = 0; n < 200; n++) begin
      acc = coord_val && rdy;
      if (pix_val) begin
        if (wr_n < 16) begin
          chk("frame_pix", {pix_x, pix_iter}, {10'(wr_n), 10'(3 * wr_n)});
        end
        wr_n++;
      end
      tick();
      if (acc) begin
        if (ca < 0) ca = cyc;
        acc_n++;
        vga_x = 10'(acc_n);
        cx = 36'(3 * acc_n);
      end
      for (int k = 0; k < 4; k++) begin
        if (ack[k]) s_done[k] = 1'b0;
        if (start[k]) begin
          s_done[k] = 1'b1;
          s_iter[k*10 +: 10] = cr[9:0];
        end
      end
      if (frame_done && cd < 0) begin
        cd = cyc;
        acc_at_done = acc_n;
        wr_at_done = wr_n;
      end
      if (cd >= 0 && cyc == cd + 10) break;
    end
    chk("frame_done", frame_done, 1);
    chk("writes_at_done", wr_at_done, 16);
    chk("no_accept", acc_n, acc_at_done);
    chk("rdy_complete", rdy, 0);
`ifdef LOADDIST_STATS_EN
    chk("frame_cycles", frame_cyc, 64'(cd - ca + 1));
`else
    chk("frame_cycles_off", frame_cyc, 0);
`endif
    coord_val = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mandel_load_dist.md
# mandel_load_dist

Load distributor between the coordinate generator and a bank of Mandelbrot iteration solvers. It accepts one pixel job at a time (VGA X/Y plus fixed-point C coordinate) over a valid/ready handshake and dispatches each job round-robin to an idle solver. It collects finished iteration counts in round-robin order and forwards them, tagged with their pixel address, to the VGA SRAM pixel writer. It also tracks frame completion.

## Interface
- NUM_SOLVERS, 4, number of solver slots (2..8)
- ITER_W, 10, width of solver iteration count
- FRAME_PIXELS, 307200, pixels per frame (640x480)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- iDraw  in  1  single-cycle pulse: abort current frame, restart counters
- iCoordVal  in  1  job valid from coordinate generator
- iVGAX  in  10  job pixel X
- iVGAY  in  9  job pixel Y
- iCoordX  in  36  job real coordinate, 4.32 fixed point
- iCoordY  in  36  job imaginary coordinate, 4.32 fixed point
- oLoadDistRdy  out  1  job ready to the coordinate generator
- oSolverStart  out  NUM_SOLVERS  one-hot start pulse
- oSolverAbort  out  NUM_SOLVERS  abort pulse to running solvers
- oSolverCr  out  36  broadcast real coordinate, valid with start
- oSolverCi  out  36  broadcast imaginary coordinate, valid with start
- iSolverDone  in  NUM_SOLVERS  level; solver holds its result until acked
- iSolverIter  in  NUM_SOLVERS*ITER_W  packed iteration counts; slot k at [k*ITER_W +: ITER_W]
- oSolverAck  out  NUM_SOLVERS  one-hot result-consumed pulse
- oPixVal  out  1  result valid to the pixel writer
- oPixX  out  10  result pixel X
- oPixY  out  9  result pixel Y
- oPixIter  out  ITER_W  result iteration count
- iPixRdy  in  1  pixel writer ready
- oFrameDone  out  1  level; all FRAME_PIXELS results written
- oFrameCycles  out  32  frame cycle count (see Configuration)

## Operation
- Each slot has a state IDLE -> RUN -> DONE -> IDLE. It also has a tag register holding the job's VGAX/VGAY.
- Dispatch:
  - oLoadDistRdy = (any slot IDLE) and top state is RUN.
  - A job is accepted on iCoordVal && oLoadDistRdy.
  - The target slot is the first IDLE slot at or after the dispatch pointer, searching cyclically.
  - The pointer then advances to target+1 mod NUM_SOLVERS.
- Accept registers the coordinates and tag and moves the slot to RUN.
- RUN -> DONE when iSolverDone[k] is sampled high.
- Collect:
  - When the output register is empty, the first DONE slot at or after the collect pointer, searching cyclically, is loaded into oPixX/Y/Iter.
  - oPixVal is set and oSolverAck[k] pulses in the same cycle. The slot returns to IDLE and the collect pointer advances.
  - Output transfer completes on oPixVal && iPixRdy.
- A written-pixel counter (19 bits) increments on each output transfer. When it reaches FRAME_PIXELS, the top state goes to COMPLETE and oFrameDone is set.
- Top FSM:
  - RUN -> COMPLETE on the frame count.
  - Any state -> FLUSH on iDraw. FLUSH lasts one cycle.
  - FLUSH -> RUN.
- FLUSH:
  - oSolverAbort pulses for every slot in RUN or DONE.
  - All slots go IDLE, both pointers go to 0, the pixel counter clears, and oPixVal and oFrameDone clear.
  - Any held output is dropped.

## Timing
- Reset values:
  - All outputs are 0, including oLoadDistRdy and oFrameCycles.
  - All slots are IDLE, pointers are 0, and the top state is RUN.
  - oLoadDistRdy rises the first cycle after reset deasserts.
- Dispatch latency: accept at edge t. oSolverStart[k] is high for exactly cycle t+1, with oSolverCr/Ci valid that same cycle.
- A slot freed by ack in cycle t is eligible for dispatch from cycle t+1. oLoadDistRdy is computed from registered slot state.
- Result latency:
  - iSolverDone is sampled at edge t, and the slot is DONE after t.
  - If the output register is empty, oPixVal is high in cycle t+1, and oSolverAck[k] is high in that same cycle t+1.
- Output register: with iPixRdy held high it sustains one result per cycle. The output register reloads in the same cycle it empties.
- oPixX/Y/Iter stay stable while oPixVal && !iPixRdy.
- iDraw has priority over accept, collect and reset-free events in the same cycle; reset has priority over iDraw.
- Jobs offered during FLUSH or COMPLETE are not accepted, because oLoadDistRdy is 0.

## Configuration
- LOADDIST_STATS_EN defined:
  - oFrameCycles counts cycles from the first accept after reset/FLUSH up to and including the cycle oFrameDone rises, then holds.
  - It clears on reset and FLUSH and saturates at 32'hFFFFFFFF.
- Not defined: oFrameCycles is constant 0 and no counter logic is generated.

## Test plan
- Reset, then hold iCoordVal=1 with 4 jobs and solvers stalled -> oSolverStart = 0001, 0010, 0100, 1000 on consecutive cycles; oLoadDistRdy=0 after the fourth accept.
- Assert iSolverDone on slots 2 and 0 in the same cycle, collect pointer=1 -> slot 2 result presented first, then slot 0; tags match the dispatched X/Y.
- Hold iPixRdy=0 for 5 cycles with oPixVal=1 -> oPix* stable, no further oSolverAck until iPixRdy=1.
- Pulse iDraw with 3 slots RUN and one result pending -> oSolverAbort=0111 (or the matching set) for one cycle, oPixVal=0, oLoadDistRdy=1 two cycles after iDraw.
- Run FRAME_PIXELS overridden to 16 with instant solvers -> oFrameDone=1 after the 16th write; no further accepts; with LOADDIST_STATS_EN, oFrameCycles equals the measured cycle count.
